codec_spi_tx: RTL

- Write-only SPI serializer that drives the audio codec's 3-wire control port.
- Sits directly downstream of the codec register configurator:
  - takes one 16-bit command word ({7-bit register address, 9-bit data}) per trigger;
  - shifts it out MSB first, in SPI mode 0;
  - frames the word with an active-low chip select; the codec latches on the rising edge of chip select.
- Reports completion through a ready handshake.

---
 rtl/codec_spi_tx_if.sv | 30 +++
 rtl/codec_spi_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/codec_spi_tx_if.sv
// codec_spi_tx_if: command handshake from the configurator
// plus the three serial pins toward the codec control port.
interface codec_spi_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  trg;
  logic                  rdy;
  logic                  mosi;
  logic                  sck;
  logic                  cs_n;

  modport master (
    output data,
    output trg,
    input  rdy,
    input  mosi,
    input  sck,
    input  cs_n
  );

  modport slave (
    input  data,
    input  trg,
    output rdy,
    output mosi,
    output sck,
    output cs_n
  );
endinterface

// File: rtl/codec_spi_tx.sv
// codec_spi_tx: write-only mode-0 SPI serializer for the codec port.
// Optional sticky busy-trigger flag: define CODEC_SPI_TX_ERR_EN.
module codec_spi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef CODEC_SPI_TX_ERR_EN
  output logic trg_err,
`endif
  codec_spi_tx_if.slave bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    TAIL,
    GUARD
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  rdy_q, rdy_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  div_wrap;
  logic                  accept;

  assign div_wrap = (div_q == DIV_LAST);
  assign accept   = rdy_q && bus.trg;

  assign bus.rdy  = rdy_q;
  assign bus.cs_n = cs_n_q;
  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;

  // State, counters, shift register and registered pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b1;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rdy_q   <= rdy_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  // Next state: every non-idle phase lasts one divider period.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    div_d   = '0;
    if (state_q != IDLE && !div_wrap) begin
      div_d = div_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        bit_d = '0;
        if (accept) begin
          state_d = SHIFT_LO;
          sh_d    = bus.data;
        end
      end
      SHIFT_LO: begin
        if (div_wrap) begin
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (div_wrap) begin
          if (bit_q == BIT_LAST) begin
            state_d = TAIL;
          end else begin
            state_d = SHIFT_LO;
            bit_d   = bit_q + 1'b1;
            sh_d    = {sh_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      TAIL: begin
        if (div_wrap) begin
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (div_wrap) begin
          state_d = IDLE;
          bit_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values decoded from the upcoming state so they register glitch-free.
  always_comb begin
    rdy_d  = (state_d == IDLE);
    cs_n_d = (state_d == IDLE) || (state_d == GUARD);
    sck_d  = (state_d == SHIFT_HI);
    mosi_d = 1'b0;
    if (state_d == SHIFT_LO || state_d == SHIFT_HI ||
        state_d == TAIL) begin
      mosi_d = sh_d[DATA_WIDTH-1];
    end
  end

`ifdef CODEC_SPI_TX_ERR_EN
  logic acc_q;

  // Sticky busy-trigger flag; a trigger held one cycle past acceptance is fine.
  always_ff @(posedge clk) begin
    if (reset) begin
      trg_err <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      acc_q <= accept;
      if (bus.trg && !rdy_q && !acc_q) begin
        trg_err <= 1'b1;
      end
    end
  end
`endif

endmodule
